// File: rtl/pw_capture_sequencer.sv
// Sniff capture sequencer: arms on request, starts on a pattern match and streams
// DATA/STAT/TIME entries into the sniff FIFO until the length limit or a disarm.
module pw_capture_sequencer #(
   parameter int pTIMESTAMP_FULL_WIDTH  = 16,
   parameter int pTIMESTAMP_SHORT_WIDTH = 3,
   parameter int pCAPTURE_LEN_WIDTH     = 16
) (
   input  logic                             fe_clk,
   input  logic                             reset_i,
   input  logic                             I_arm,
   input  logic                             I_match,
   input  logic [pCAPTURE_LEN_WIDTH-1:0]    I_capture_len,
   input  logic                             I_timestamps_disable,
   input  logic                             I_event_valid,
   input  logic                             I_event_is_stat,
   input  logic [7:0]                       I_event_data,
   input  logic [4:0]                       I_event_stat,
   input  logic                             I_fifo_full,
   output logic                             O_fifo_wr,
   output logic [1:0]                       O_fifo_cmd,
   output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fifo_time,
   output logic [7:0]                       O_fifo_data,
   output logic [4:0]                       O_fifo_stat,
   output logic                             O_capturing,
   output logic                             O_done,
   output logic                             O_overflow,
   output logic [pCAPTURE_LEN_WIDTH-1:0]    O_entry_count
);

   // state     | meaning
   // S_IDLE    | not armed; waits for I_arm
   // S_ARMED   | armed; counters cleared; waits for I_match
   // S_CAPTURE | streaming entries into the FIFO
   // S_DONE    | length limit reached; waits for disarm

   localparam int TW = pTIMESTAMP_FULL_WIDTH;
   localparam int SW = pTIMESTAMP_SHORT_WIDTH;
   localparam int CW = pCAPTURE_LEN_WIDTH;

   localparam logic [1:0] FE_FIFO_CMD_DATA = 2'd0;
   localparam logic [1:0] FE_FIFO_CMD_STAT = 2'd1;
   localparam logic [1:0] FE_FIFO_CMD_TIME = 2'd2;

   localparam logic [TW-1:0] GAP_MAX   = '1;
   localparam logic [CW-1:0] COUNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   gap_q, gap_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   len_q, len_d;
   logic            overflow_q, overflow_d;

   logic            pend_valid_q, pend_valid_d;
   logic            pend_is_stat_q, pend_is_stat_d;
   logic [7:0]      pend_data_q, pend_data_d;
   logic [4:0]      pend_stat_q, pend_stat_d;

   logic            wr_q, wr_d;
   logic [1:0]      cmd_q, cmd_d;
   logic [TW-1:0]   time_q, time_d;
   logic [7:0]      data_q, data_d;
   logic [4:0]      stat_q, stat_d;

   logic            try_wr;
   logic [1:0]      entry_cmd;
   logic [TW-1:0]   entry_time;
   logic [7:0]      entry_data;
   logic [4:0]      entry_stat;
   logic [CW-1:0]   count_inc;
   logic            short_gap;

   // A gap fits the short field when every bit above it is zero.
   assign short_gap = (gap_q[TW-1:SW] == '0);
   assign count_inc = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;

   always_ff @(posedge fe_clk) begin
      if (reset_i) begin
         state_q        <= S_IDLE;
         gap_q          <= '0;
         count_q        <= '0;
         len_q          <= '0;
         overflow_q     <= 1'b0;
         pend_valid_q   <= 1'b0;
         pend_is_stat_q <= 1'b0;
         pend_data_q    <= '0;
         pend_stat_q    <= '0;
         wr_q           <= 1'b0;
         cmd_q          <= '0;
         time_q         <= '0;
         data_q         <= '0;
         stat_q         <= '0;
      end else begin
         state_q        <= state_d;
         gap_q          <= gap_d;
         count_q        <= count_d;
         len_q          <= len_d;
         overflow_q     <= overflow_d;
         pend_valid_q   <= pend_valid_d;
         pend_is_stat_q <= pend_is_stat_d;
         pend_data_q    <= pend_data_d;
         pend_stat_q    <= pend_stat_d;
         wr_q           <= wr_d;
         cmd_q          <= cmd_d;
         time_q         <= time_d;
         data_q         <= data_d;
         stat_q         <= stat_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      gap_d          = gap_q;
      count_d        = count_q;
      len_d          = len_q;
      overflow_d     = overflow_q;
      pend_valid_d   = pend_valid_q;
      pend_is_stat_d = pend_is_stat_q;
      pend_data_d    = pend_data_q;
      pend_stat_d    = pend_stat_q;
      wr_d           = 1'b0;
      cmd_d          = FE_FIFO_CMD_DATA;
      time_d         = '0;
      data_d         = '0;
      stat_d         = '0;
      try_wr         = 1'b0;
      entry_cmd      = FE_FIFO_CMD_DATA;
      entry_time     = '0;
      entry_data     = '0;
      entry_stat     = '0;

      case (state_q)
         S_IDLE: begin
            pend_valid_d = 1'b0;
            if (I_arm) state_d = S_ARMED;
         end

         S_ARMED: begin
            gap_d        = '0;
            count_d      = '0;
            overflow_d   = 1'b0;
            pend_valid_d = 1'b0;
            if (!I_arm) begin
               state_d = S_IDLE;
            end else if (I_match) begin
               state_d = S_CAPTURE;
               len_d   = I_capture_len;
            end
         end

         S_CAPTURE: begin
            if (!I_arm) begin
               state_d      = S_IDLE;
               pend_valid_d = 1'b0;
            end else begin
               if (pend_valid_q) begin
                  // second half of a TIME/event pair; a colliding event is lost
                  try_wr       = 1'b1;
                  entry_cmd    = pend_is_stat_q ? FE_FIFO_CMD_STAT : FE_FIFO_CMD_DATA;
                  entry_data   = pend_is_stat_q ? 8'd0 : pend_data_q;
                  entry_stat   = pend_is_stat_q ? pend_stat_q : 5'd0;
                  pend_valid_d = 1'b0;
                  if (I_event_valid) overflow_d = 1'b1;
               end else if (I_event_valid) begin
                  try_wr     = 1'b1;
                  entry_data = I_event_is_stat ? 8'd0 : I_event_data;
                  entry_stat = I_event_is_stat ? I_event_stat : 5'd0;
                  entry_cmd  = I_event_is_stat ? FE_FIFO_CMD_STAT : FE_FIFO_CMD_DATA;
                  if (I_timestamps_disable) begin
                     entry_time = '0;
                  end else if (short_gap) begin
                     entry_time = gap_q;
                  end else begin
                     entry_cmd      = FE_FIFO_CMD_TIME;
                     entry_time     = gap_q;
                     entry_data     = '0;
                     entry_stat     = '0;
                     pend_valid_d   = 1'b1;
                     pend_is_stat_d = I_event_is_stat;
                     pend_data_d    = I_event_data;
                     pend_stat_d    = I_event_stat;
                  end
               end else if (!I_timestamps_disable && gap_q == GAP_MAX) begin
                  try_wr     = 1'b1;
                  entry_cmd  = FE_FIFO_CMD_TIME;
                  entry_time = GAP_MAX;
               end

               if (try_wr && !I_fifo_full) begin
                  wr_d    = 1'b1;
                  cmd_d   = entry_cmd;
                  time_d  = entry_time;
                  data_d  = entry_data;
                  stat_d  = entry_stat;
                  gap_d   = '0;
                  count_d = count_inc;
                  if (len_q != '0 && count_inc == len_q) begin
                     state_d      = S_DONE;
                     pend_valid_d = 1'b0;
                  end
               end else begin
                  if (try_wr) overflow_d = 1'b1;
                  gap_d = gap_q + 1'b1;
               end
            end
         end

         S_DONE: begin
            pend_valid_d = 1'b0;
            if (!I_arm) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign O_fifo_wr     = wr_q;
   assign O_fifo_cmd    = cmd_q;
   assign O_fifo_time   = time_q;
   assign O_fifo_data   = data_q;
   assign O_fifo_stat   = stat_q;
   assign O_capturing   = (state_q == S_CAPTURE);
   assign O_done        = (state_q == S_DONE);
   assign O_overflow    = overflow_q;
   assign O_entry_count = count_q;

endmodule

// File: tb/tb_pw_capture_sequencer.sv
// Directed bench for pw_capture_sequencer: hand-computed vectors for each capture scenario.
module tb_pw_capture_sequencer;

   localparam logic [1:0] CMD_DATA = 2'd0;
   localparam logic [1:0] CMD_STAT = 2'd1;
   localparam logic [1:0] CMD_TIME = 2'd2;

   logic        fe_clk;
   logic        reset_i;
   logic        I_arm;
   logic        I_match;
   logic [15:0] I_capture_len;
   logic        I_timestamps_disable;
   logic        I_event_valid;
   logic        I_event_is_stat;
   logic [7:0]  I_event_data;
   logic [4:0]  I_event_stat;
   logic        I_fifo_full;
   logic        O_fifo_wr;
   logic [1:0]  O_fifo_cmd;
   logic [15:0] O_fifo_time;
   logic [7:0]  O_fifo_data;
   logic [4:0]  O_fifo_stat;
   logic        O_capturing;
   logic        O_done;
   logic        O_overflow;
   logic [15:0] O_entry_count;

   int n_vec = 0;
   int n_err = 0;
   int n_wr;
   logic [7:0] last_data;

   pw_capture_sequencer #(
      .pTIMESTAMP_FULL_WIDTH (16),
      .pTIMESTAMP_SHORT_WIDTH(3),
      .pCAPTURE_LEN_WIDTH    (16)
   ) dut (
      .fe_clk              (fe_clk),
      .reset_i             (reset_i),
      .I_arm               (I_arm),
      .I_match             (I_match),
      .I_capture_len       (I_capture_len),
      .I_timestamps_disable(I_timestamps_disable),
      .I_event_valid       (I_event_valid),
      .I_event_is_stat     (I_event_is_stat),
      .I_event_data        (I_event_data),
      .I_event_stat        (I_event_stat),
      .I_fifo_full         (I_fifo_full),
      .O_fifo_wr           (O_fifo_wr),
      .O_fifo_cmd          (O_fifo_cmd),
      .O_fifo_time         (O_fifo_time),
      .O_fifo_data         (O_fifo_data),
      .O_fifo_stat         (O_fifo_stat),
      .O_capturing         (O_capturing),
      .O_done              (O_done),
      .O_overflow          (O_overflow),
      .O_entry_count       (O_entry_count)
   );

   initial fe_clk = 1'b0;
   always #5 fe_clk = ~fe_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge fe_clk);
      #1;
   endtask

   // IDLE -> ARMED -> CAPTURE; returns in the first CAPTURE cycle (gap = 0)
   task automatic arm_match();
      I_arm = 1'b1;
      tick();
      I_match = 1'b1;
      tick();
      I_match = 1'b0;
   endtask

   task automatic disarm();
      I_arm = 1'b0;
      tick();
   endtask

   // event presented for one cycle; returns with its registered write visible
   task automatic pulse_event(input logic is_stat, input logic [7:0] data, input logic [4:0] stat);
      I_event_valid   = 1'b1;
      I_event_is_stat = is_stat;
      I_event_data    = data;
      I_event_stat    = stat;
      tick();
      I_event_valid   = 1'b0;
      I_event_is_stat = 1'b0;
      I_event_data    = 8'h00;
      I_event_stat    = 5'h00;
   endtask

   initial begin
      reset_i = 1'b1;
      I_arm = 1'b0;
      I_match = 1'b0;
      I_capture_len = 16'd0;
      I_timestamps_disable = 1'b0;
      I_event_valid = 1'b0;
      I_event_is_stat = 1'b0;
      I_event_data = 8'h00;
      I_event_stat = 5'h00;
      I_fifo_full = 1'b0;
      tick();
      tick();
      reset_i = 1'b0;
      tick();

      check_val("rst_wr",    O_fifo_wr,     0);
      check_val("rst_cap",   O_capturing,   0);
      check_val("rst_done",  O_done,        0);
      check_val("rst_ovf",   O_overflow,    0);
      check_val("rst_count", O_entry_count, 0);

      // two DATA events two cycles apart, then a STAT event
      arm_match();
      check_val("t1_cap", O_capturing, 1);
      pulse_event(1'b0, 8'hA5, 5'h00);
      check_val("t1_wr0",   O_fifo_wr,   1);
      check_val("t1_cmd0",  O_fifo_cmd,  CMD_DATA);
      check_val("t1_time0", O_fifo_time, 0);
      check_val("t1_data0", O_fifo_data, 8'hA5);
      tick();
      check_val("t1_idle", O_fifo_wr, 0);
      pulse_event(1'b0, 8'h3C, 5'h00);
      check_val("t1_wr1",   O_fifo_wr,     1);
      check_val("t1_time1", O_fifo_time,   1);
      check_val("t1_data1", O_fifo_data,   8'h3C);
      check_val("t1_count", O_entry_count, 2);
      tick();
      pulse_event(1'b1, 8'hFF, 5'h15);
      check_val("t1_scmd",  O_fifo_cmd,  CMD_STAT);
      check_val("t1_stime", O_fifo_time, 1);
      check_val("t1_sdata", O_fifo_data, 0);
      check_val("t1_sstat", O_fifo_stat, 5'h15);
      disarm();
      check_val("t1_disarm", O_capturing, 0);

      // long gap: TIME entry then the deferred DATA entry
      arm_match();
      repeat (20) tick();
      pulse_event(1'b0, 8'h77, 5'h00);
      check_val("t2_wr_time", O_fifo_wr,     1);
      check_val("t2_cmd_time", O_fifo_cmd,   CMD_TIME);
      check_val("t2_time",    O_fifo_time,   20);
      check_val("t2_tdata",   O_fifo_data,   0);
      check_val("t2_count1",  O_entry_count, 1);
      tick();
      check_val("t2_wr_data", O_fifo_wr,     1);
      check_val("t2_cmd_data", O_fifo_cmd,   CMD_DATA);
      check_val("t2_dtime",   O_fifo_time,   0);
      check_val("t2_data",    O_fifo_data,   8'h77);
      check_val("t2_count2",  O_entry_count, 2);
      tick();
      check_val("t2_after", O_fifo_wr, 0);
      disarm();

      // timestamps disabled: long gap still gives one entry with time 0
      arm_match();
      repeat (20) tick();
      I_timestamps_disable = 1'b1;
      pulse_event(1'b0, 8'h5A, 5'h00);
      check_val("td_cmd",  O_fifo_cmd,  CMD_DATA);
      check_val("td_time", O_fifo_time, 0);
      check_val("td_data", O_fifo_data, 8'h5A);
      tick();
      check_val("td_single", O_fifo_wr, 0);
      I_timestamps_disable = 1'b0;
      disarm();

      // timeout TIME entry at all-ones gap
      arm_match();
      repeat (65535) tick();
      check_val("t3_pre", O_fifo_wr, 0);
      tick();
      check_val("t3_wr",    O_fifo_wr,     1);
      check_val("t3_cmd",   O_fifo_cmd,    CMD_TIME);
      check_val("t3_time",  O_fifo_time,   16'hFFFF);
      check_val("t3_ovf",   O_overflow,    0);
      check_val("t3_count", O_entry_count, 1);
      tick();
      pulse_event(1'b0, 8'h11, 5'h00);
      check_val("t3_restart", O_fifo_time, 1);
      disarm();

      // length limit of 3 with five events offered
      I_capture_len = 16'd3;
      arm_match();
      n_wr = 0;
      last_data = 8'h00;
      for (int i = 0; i < 5; i++) begin
         pulse_event(1'b0, 8'h10 + 8'(i), 5'h00);
         if (O_fifo_wr) begin n_wr++; last_data = O_fifo_data; end
         tick();
         if (O_fifo_wr) begin n_wr++; last_data = O_fifo_data; end
      end
      check_val("t4_writes", n_wr,          3);
      check_val("t4_last",   last_data,     8'h12);
      check_val("t4_done",   O_done,        1);
      check_val("t4_cap",    O_capturing,   0);
      check_val("t4_count",  O_entry_count, 3);
      I_capture_len = 16'd0;
      disarm();
      check_val("t4_undone", O_done,      0);
      check_val("t4_idle",   O_capturing, 0);

      // FIFO full suppresses the write and does not reset the gap
      arm_match();
      I_fifo_full = 1'b1;
      pulse_event(1'b0, 8'h99, 5'h00);
      check_val("t5_nowr",  O_fifo_wr,     0);
      check_val("t5_ovf",   O_overflow,    1);
      check_val("t5_count", O_entry_count, 0);
      I_fifo_full = 1'b0;
      tick();
      pulse_event(1'b0, 8'h98, 5'h00);
      check_val("t5_gap",    O_fifo_time, 2);
      check_val("t5_ovfheld", O_overflow, 1);
      disarm();
      check_val("t5_ovfidle", O_overflow, 1);
      arm_match();
      check_val("t5_rearm", O_overflow, 0);

      // disarm between the TIME entry and its deferred event
      repeat (10) tick();
      pulse_event(1'b0, 8'h44, 5'h00);
      check_val("t6_time", O_fifo_cmd, CMD_TIME);
      I_arm = 1'b0;
      tick();
      check_val("t6_nopend", O_fifo_wr,   0);
      check_val("t6_cap",    O_capturing, 0);
      tick();
      check_val("t6_nopend2", O_fifo_wr, 0);

      // synchronous reset in the middle of a capture
      arm_match();
      I_fifo_full = 1'b1;
      pulse_event(1'b0, 8'h01, 5'h00);
      I_fifo_full = 1'b0;
      tick();
      pulse_event(1'b0, 8'h02, 5'h00);
      check_val("t7_pre", O_entry_count, 1);
      reset_i = 1'b1;
      I_event_valid = 1'b1;
      I_event_data = 8'h03;
      tick();
      I_event_valid = 1'b0;
      I_event_data = 8'h00;
      check_val("t7_wr",    O_fifo_wr,     0);
      check_val("t7_data",  O_fifo_data,   0);
      check_val("t7_cap",   O_capturing,   0);
      check_val("t7_ovf",   O_overflow,    0);
      check_val("t7_count", O_entry_count, 0);
      check_val("t7_done",  O_done,        0);
      reset_i = 1'b0;
      I_arm = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pw_capture_sequencer.md
Name: pw_capture_sequencer

Overview:
Front-end capture controller in the fe_clk domain. It sequences one sniff capture: arm, wait for a pattern match, stream events into the sniff FIFO, then stop.
It builds the FIFO write stream: command code, time field and payload. It inserts long-timestamp (TIME) entries when the gap since the last entry exceeds the short time field.
It enforces the capture length and reports done/overflow status back toward the register block.

Parameters:
pTIMESTAMP_FULL_WIDTH, 16, width of the inter-entry gap counter and of the TIME entry payload
pTIMESTAMP_SHORT_WIDTH, 3, width of the time field carried in DATA/STAT entries
pCAPTURE_LEN_WIDTH, 16, width of the capture length and entry counter

Ports:
fe_clk  in  1  front-end clock; all logic is synchronous to it
reset_i  in  1  synchronous active-high reset
I_arm  in  1  arm level, already synchronized to fe_clk; low = disarm
I_match  in  1  single-cycle pattern-match pulse
I_capture_len  in  pCAPTURE_LEN_WIDTH  number of FIFO entries to capture; 0 = unlimited
I_timestamps_disable  in  1  when high, time fields are zero and no TIME entries are generated
I_event_valid  in  1  single-cycle front-end event
I_event_is_stat  in  1  qualifies I_event_valid: 1 = STAT event, 0 = DATA event
I_event_data  in  8  data byte
I_event_stat  in  5  status bits
I_fifo_full  in  1  sniff FIFO full flag (write domain)
O_fifo_wr  out  1  FIFO write strobe
O_fifo_cmd  out  2  `FE_FIFO_CMD_DATA / `FE_FIFO_CMD_STAT / `FE_FIFO_CMD_TIME
O_fifo_time  out  pTIMESTAMP_FULL_WIDTH  time field; only the low pTIMESTAMP_SHORT_WIDTH bits are meaningful for DATA/STAT
O_fifo_data  out  8  data payload; 0 for STAT and TIME entries
O_fifo_stat  out  5  status payload; 0 for TIME entries
O_capturing  out  1  high while in CAPTURE
O_done  out  1  sticky capture-complete flag
O_overflow  out  1  sticky flag: entry lost
O_entry_count  out  pCAPTURE_LEN_WIDTH  number of entries written this capture

Behaviour:
- Reset: state IDLE. All outputs are 0. The gap counter, entry counter and pending-event register are cleared.
- States:
  - IDLE -> ARMED when I_arm is high and O_done is 0.
  - ARMED -> CAPTURE on I_match. Also in ARMED: gap counter cleared, entry count cleared, O_overflow cleared.
  - CAPTURE -> DONE when a write brings O_entry_count to I_capture_len (nonzero), including any pending entry.
  - DONE: O_done = 1; remains until I_arm goes low, then -> IDLE with O_done cleared.
  - Any state -> IDLE one cycle after I_arm goes low. A pending event is discarded. O_overflow is held until the next ARMED.
- Events are accepted only in CAPTURE, starting the cycle after entry; the event in the I_match cycle is not captured.
- Gap counter (pTIMESTAMP_FULL_WIDTH bits):
  - Increments every cycle in CAPTURE.
  - Reset to 0 on the cycle of each FIFO write, i.e. it counts cycles since the last entry.
  - On entry to CAPTURE it starts at 0.
- Event handling (O_fifo_* registered; latency 1 cycle from I_event_valid):
  - gap < 2^pTIMESTAMP_SHORT_WIDTH: write one DATA or STAT entry with time = gap.
  - Otherwise, cycle N+1: write TIME with time = gap. Store the event in the pending register. Cycle N+2: write the event with time = 0.
  - Timeout: if the gap counter reaches all-ones with no event, write TIME with time = all-ones and reset the counter. If an event arrives that cycle, the event is treated as a long gap (TIME then pending).
  - I_timestamps_disable = 1: every event is a single entry with time 0; no TIME entries ever.
  - A new event while an entry is pending: the new event is dropped and O_overflow is set. The front end guarantees at most one event per 2 cycles.
- FIFO full: any write attempted while I_fifo_full is high is suppressed and O_overflow is set. Suppressed entries do not increment O_entry_count and do not reset the gap counter.
- O_entry_count saturates at all-ones.
- Length limit: no write after the one that reaches I_capture_len. A pending event at that point is discarded.
- I_capture_len = 0: capture continues until disarm.
- I_capture_len is sampled on the ARMED -> CAPTURE transition. Changes mid-capture have no effect.

Test Plan:
- Arm, match, DATA events 0xA5 and 0x3C at 2-cycle spacing, len=0 -> two DATA writes, time=1 for the second, data A5/3C, count=2.
- Arm, match, then event after 20 idle cycles (SHORT=3) -> TIME entry with time=20, next cycle DATA with time=0, count=2.
- Arm, match, no events for 65535 cycles -> TIME entry with time=0xFFFF, counter restarts, O_overflow=0.
- len=3, stream 5 events -> exactly 3 writes, O_done=1, O_capturing=0; drop arm -> O_done=0, state IDLE.
- I_fifo_full held high during an event -> no O_fifo_wr, O_overflow=1, count unchanged; re-arm -> O_overflow=0.
- Deassert I_arm mid-TIME/pending pair -> pending entry never written, O_capturing=0 next cycle; reset_i mid-capture -> all outputs 0 next cycle.
